cache_dm_ctrl: RTL and testbench

Parametrised direct-mapped, write-through cache controller placed between the processor's memory port and the shared RAM. Read hits return data in one cycle. Read misses fetch the word from RAM over a fixed-latency strobe and allocate the line. Writes update a hitting line and are always written through to RAM. It generalises the fixed-size cache with configurable line count, memory latency, hit reporting and bulk invalidate.

---
 rtl/cache_dm_ctrl.sv | 166 ++++++++++++++++
 tb/tb_cache_dm_ctrl.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cache_dm_ctrl.sv
// ---------------------------------------------------------------------------
// cache_dm_ctrl
//
// Direct-mapped, write-through cache controller between a processor memory
// port and a shared fixed-latency RAM.
//
//   * Read hit  : data_out/odv/hit one cycle after the accepting edge, no RAM
//                 access, controller stays idle (one hit per cycle possible).
//   * Read miss : RAM read strobe for mem_lat cycles, then the fetched word
//                 is allocated into the line and returned with odv.
//   * Write     : a hitting line is updated on the accepting edge (a miss
//                 does not allocate); the word is always written through to
//                 RAM with a mem_lat-cycle strobe.
//   * inv       : while idle, clears every valid bit; a ce_in in the same
//                 cycle is dropped.
//
// Handshake: a request is taken on a rising edge where ce_in=1, inv=0 and
// busy=0. Requests presented while busy are ignored, so the requester must
// hold ce_in or retry. odv and hit are one-cycle pulses.
//
// Ports
//   clk          clock, rising edge
//   clr          asynchronous active-low reset
//   addr_in      request address
//   data_in      write data from processor
//   rw_in        1 = read, 0 = write
//   ce_in        request strobe
//   inv          invalidate all lines
//   data_out     read data to processor
//   odv          read data valid pulse
//   hit          lookup result pulse for the accepted request
//   busy         controller cannot accept a request
//   addr_out     RAM address
//   data_wr_out  RAM write data
//   data_rd_in   RAM read data
//   rw_out       RAM direction, 1 = read
//   ce_out       RAM enable
// ---------------------------------------------------------------------------
module cache_dm_ctrl #(
    parameter int d_width   = 4,
    parameter int a_width   = 8,
    parameter int idx_width = 2,
    parameter int mem_lat   = 2
) (
    input  logic               clk,
    input  logic               clr,
    input  logic [a_width-1:0] addr_in,
    input  logic [d_width-1:0] data_in,
    input  logic               rw_in,
    input  logic               ce_in,
    input  logic               inv,
    output logic [d_width-1:0] data_out,
    output logic               odv,
    output logic               hit,
    output logic               busy,
    output logic [a_width-1:0] addr_out,
    output logic [d_width-1:0] data_wr_out,
    input  logic [d_width-1:0] data_rd_in,
    output logic               rw_out,
    output logic               ce_out
);

    localparam int lines     = 1 << idx_width;
    localparam int tag_width = a_width - idx_width;
    localparam int cnt_width = $clog2(mem_lat + 1);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] FILL  = 2'd1;
    localparam logic [1:0] WRITE = 2'd2;

    logic [1:0]           state;
    logic [cnt_width-1:0] cnt;
    logic [lines-1:0]     valid;
    logic [tag_width-1:0] tag_mem  [lines];
    logic [d_width-1:0]   data_mem [lines];

    logic [idx_width-1:0] req_idx;
    logic [tag_width-1:0] req_tag;
    logic [idx_width-1:0] lat_idx;
    logic [tag_width-1:0] lat_tag;
    logic                 lookup_hit;
    logic                 accept;
    logic                 last;

    assign req_idx    = addr_in[idx_width-1:0];
    assign req_tag    = addr_in[a_width-1:idx_width];
    // addr_out holds the latched request address for the whole RAM access.
    assign lat_idx    = addr_out[idx_width-1:0];
    assign lat_tag    = addr_out[a_width-1:idx_width];
    assign lookup_hit = valid[req_idx] && (tag_mem[req_idx] == req_tag);
    assign accept     = (state == IDLE) && ce_in && !inv;
    assign last       = (cnt == cnt_width'(1));

    // Decoded straight from the state register so a reset mid-access drops
    // the RAM strobe asynchronously.
    assign busy   = (state != IDLE);
    assign ce_out = (state != IDLE);
    assign rw_out = (state == FILL);

    // Control path, valid bits and registered outputs.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state       <= IDLE;
            cnt         <= '0;
            valid       <= '0;
            addr_out    <= '0;
            data_wr_out <= '0;
            data_out    <= '0;
            odv         <= 1'b0;
            hit         <= 1'b0;
        end else begin
            odv <= 1'b0;
            hit <= 1'b0;
            case (state)
                IDLE: begin
                    if (inv) begin
                        valid <= '0;
                    end else if (ce_in) begin
                        addr_out    <= addr_in;
                        data_wr_out <= data_in;
                        hit         <= lookup_hit;
                        cnt         <= cnt_width'(mem_lat);
                        if (rw_in && lookup_hit) begin
                            data_out <= data_mem[req_idx];
                            odv      <= 1'b1;
                        end else if (rw_in) begin
                            state <= FILL;
                        end else begin
                            state <= WRITE;
                        end
                    end
                end
                FILL: begin
                    if (last) begin
                        valid[lat_idx] <= 1'b1;
                        data_out       <= data_rd_in;
                        odv            <= 1'b1;
                        state          <= IDLE;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                WRITE: begin
                    if (last) begin
                        state <= IDLE;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Tag and data storage survive reset; only the valid bits are cleared.
    // The clr gate stops a request presented during reset from writing a line.
    always_ff @(posedge clk) begin
        if (clr && accept && !rw_in && lookup_hit) begin
            data_mem[req_idx] <= data_in;
        end else if (clr && (state == FILL) && last) begin
            data_mem[lat_idx] <= data_rd_in;
            tag_mem[lat_idx]  <= lat_tag;
        end
    end

endmodule

// File: tb/tb_cache_dm_ctrl.sv
// ---------------------------------------------------------------------------
// tb_cache_dm_ctrl
//
// Bench for cache_dm_ctrl with d_width=4, a_width=8, idx_width=2, mem_lat=2.
// The RAM behind the controller is a plain array. A reference cache model
// (per-line valid/tag/data plus a shadow of RAM contents) predicts hit/miss,
// read data and RAM traffic; read data expectations go through exp_q and are
// popped whenever odv is seen.
// ---------------------------------------------------------------------------
module tb_cache_dm_ctrl;

  localparam int DW  = 4;
  localparam int AW  = 8;
  localparam int IW  = 2;
  localparam int LAT = 2;

  // clock / reset
  logic clk = 1'b0;
  logic clr;
  always #5 clk = ~clk;

  logic [AW-1:0] addr_in;
  logic [DW-1:0] data_in;
  logic          rw_in;
  logic          ce_in;
  logic          inv;
  logic [DW-1:0] data_out;
  logic          odv;
  logic          hit;
  logic          busy;
  logic [AW-1:0] addr_out;
  logic [DW-1:0] data_wr_out;
  logic [DW-1:0] data_rd_in;
  logic          rw_out;
  logic          ce_out;

  cache_dm_ctrl #(
    .d_width  (DW),
    .a_width  (AW),
    .idx_width(IW),
    .mem_lat  (LAT)
  ) dut (
    .clk        (clk),
    .clr        (clr),
    .addr_in    (addr_in),
    .data_in    (data_in),
    .rw_in      (rw_in),
    .ce_in      (ce_in),
    .inv        (inv),
    .data_out   (data_out),
    .odv        (odv),
    .hit        (hit),
    .busy       (busy),
    .addr_out   (addr_out),
    .data_wr_out(data_wr_out),
    .data_rd_in (data_rd_in),
    .rw_out     (rw_out),
    .ce_out     (ce_out)
  );

  // external RAM
  logic [DW-1:0] ram [256];
  assign data_rd_in = ram[addr_out];
  always @(posedge clk) begin
    if (ce_out && !rw_out) ram[addr_out] <= data_wr_out;
  end

  // reference model
  logic [DW-1:0]    exp_mem [256];
  bit               m_valid [4];
  logic [AW-IW-1:0] m_tag   [4];
  logic [DW-1:0]    m_data  [4];
  int               ram_acc = 0;

  // scoreboard
  logic [DW-1:0] exp_q[$];
  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_inv();
    for (int i = 0; i < 4; i++) m_valid[i] = 0;
  endtask

  always @(negedge clk) begin
    if (clr && odv) begin
      if (exp_q.size() == 0) check("odv_spurious", 1, 0);
      else check("rd_data", data_out, exp_q.pop_front());
    end
  end

  // driver: one request from idle to completion; poke pulses ce_in while busy
  task automatic do_req(input logic [AW-1:0] a, input logic rw, input logic [DW-1:0] d,
                        input bit poke);
    int idx = int'(a[IW-1:0]);
    logic [AW-IW-1:0] tg = a[AW-1:IW];
    bit eh;
    int n;
    @(negedge clk);
    check("busy_idle", busy, 0);
    eh = m_valid[idx] && (m_tag[idx] == tg);
    addr_in = a;
    rw_in   = rw;
    data_in = d;
    ce_in   = 1'b1;
    if (rw) exp_q.push_back(eh ? m_data[idx] : exp_mem[a]);
    @(negedge clk);
    ce_in = 1'b0;
    check("hit", hit, eh);
    if (rw && eh) begin
      check("hit_ce", ce_out, 0);
      check("hit_busy", busy, 0);
      check("hit_odv", odv, 1);
    end else begin
      check("odv_early", odv, 0);
      n = 0;
      while (ce_out && n < LAT + 4) begin
        check("rw_out", rw_out, rw);
        check("addr_out", addr_out, a);
        check("busy_acc", busy, 1);
        if (!rw) check("wr_data", data_wr_out, d);
        if (n == 1) check("hit_pulse", hit, 0);
        if (poke && n == 0) begin
          ce_in   = 1'b1;
          addr_in = a ^ 8'h80;
          rw_in   = 1'b1;
        end else begin
          ce_in = 1'b0;
        end
        n++;
        @(negedge clk);
      end
      ce_in = 1'b0;
      ram_acc++;
      check("ram_cycles", n, LAT);
      check("busy_done", busy, 0);
      check("odv_done", odv, rw);
      if (rw) begin
        m_valid[idx] = 1;
        m_tag[idx]   = tg;
        m_data[idx]  = exp_mem[a];
      end else begin
        exp_mem[a] = d;
        if (eh) m_data[idx] = d;
        check("ram_wr", ram[a], d);
      end
    end
  endtask

  task automatic do_inv(input logic [AW-1:0] a);
    @(negedge clk);
    check("inv_busy", busy, 0);
    addr_in = a;
    rw_in   = 1'b1;
    ce_in   = 1'b1;
    inv     = 1'b1;
    @(negedge clk);
    ce_in = 1'b0;
    inv   = 1'b0;
    check("inv_hit", hit, 0);
    check("inv_odv", odv, 0);
    check("inv_ce", ce_out, 0);
    model_inv();
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin : main
    int acc0;
    clr     = 1'b0;
    addr_in = '0;
    data_in = '0;
    rw_in   = 1'b0;
    ce_in   = 1'b0;
    inv     = 1'b0;
    for (int i = 0; i < 256; i++) begin
      ram[i]     = 4'($urandom);
      exp_mem[i] = ram[i];
    end
    ram[8'h25]     = 4'hA;
    exp_mem[8'h25] = 4'hA;
    model_inv();

    // reset state
    repeat (2) @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_ce", ce_out, 0);
    check("rst_odv", odv, 0);
    check("rst_hit", hit, 0);
    check("rst_dout", data_out, 0);
    check("rst_aout", addr_out, 0);
    check("rst_wout", data_wr_out, 0);
    clr = 1'b1;

    // read miss then hit on 0x25
    do_req(8'h25, 1'b1, 4'h0, 0);
    check("miss_data_seen", exp_mem[8'h25], 4'hA);
    do_req(8'h25, 1'b1, 4'h0, 0);

    // write hit, then read back without RAM access
    acc0 = ram_acc;
    do_req(8'h25, 1'b0, 4'h3, 0);
    do_req(8'h25, 1'b1, 4'h0, 0);
    check("wr_hit_acc", ram_acc - acc0, 1);

    // conflict on index 1
    do_inv(8'h00);
    acc0 = ram_acc;
    do_req(8'h25, 1'b1, 4'h0, 0);
    do_req(8'h45, 1'b1, 4'h0, 0);
    do_req(8'h25, 1'b1, 4'h0, 0);
    check("conflict_acc", ram_acc - acc0, 3);

    // write miss does not allocate
    acc0 = ram_acc;
    do_req(8'h10, 1'b0, 4'h7, 0);
    do_req(8'h10, 1'b1, 4'h0, 0);
    check("wmiss_acc", ram_acc - acc0, 2);

    // invalidate with a simultaneous request
    do_req(8'h25, 1'b1, 4'h0, 0);
    do_inv(8'h25);
    acc0 = ram_acc;
    do_req(8'h25, 1'b1, 4'h0, 0);
    check("inv_acc", ram_acc - acc0, 1);

    // reset in the first FILL cycle
    @(negedge clk);
    addr_in = 8'h30;
    rw_in   = 1'b1;
    ce_in   = 1'b1;
    @(negedge clk);
    ce_in = 1'b0;
    check("fill_start", ce_out, 1);
    #1 clr = 1'b0;
    #1;
    check("abort_ce", ce_out, 0);
    check("abort_busy", busy, 0);
    check("abort_rw", rw_out, 0);
    check("abort_odv", odv, 0);
    check("abort_hit", hit, 0);
    check("abort_dout", data_out, 0);
    check("abort_aout", addr_out, 0);
    check("abort_wout", data_wr_out, 0);
    model_inv();
    @(negedge clk);
    clr = 1'b1;
    do_req(8'h30, 1'b1, 4'h0, 0);

    // ce_in during busy is dropped
    do_req(8'h3c, 1'b1, 4'h0, 1);
    do_req(8'h13, 1'b0, 4'h9, 1);

    // randomized traffic
    repeat (80) begin
      if ($urandom_range(0, 11) == 0) begin
        do_inv(8'($urandom_range(0, 255)));
      end else begin
        do_req(8'($urandom_range(0, 31)), 1'($urandom_range(0, 2) != 0),
               4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)));
      end
    end

    repeat (3) @(negedge clk);
    check("exp_q_empty", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
